fetch_cycle: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It is the requesting end of the instruction-memory read port. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. It also handles stall, flush and branch/jump redirect requests from the hazard unit and the execute stage.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/pc_register.sv | 34 +++
 rtl/fetch_cycle.sv | 82 ++++++++
 tb/tb_fetch_cycle.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline types and constants
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0: the canonical pipeline bubble
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter flop with enable and async active-low reset
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [XLEN-1:0] pc_next_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_i) begin
      pc_d = pc_next_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_cycle.sv
// rtl/fetch_cycle.sv - instruction fetch stage: PC, imem address and IF/ID register
module fetch_cycle
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [XLEN-1:0] IMemAddr,
  input  logic [XLEN-1:0] IMemRD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] pc_plus4f;
  logic [XLEN-1:0] pc_next;
  logic            pc_en;
  logic            unused_target_lsbs;

  if_id_t if_id_q;
  if_id_t if_id_d;

  assign pc_plus4f          = pcf + 32'd4;
  assign pc_next            = PCSrcE ? {PCTargetE[XLEN-1:2], 2'b00} : pc_plus4f;
  // a redirect must land even while fetch is stalled
  assign pc_en              = !StallF || PCSrcE;
  assign unused_target_lsbs = ^PCTargetE[1:0];

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk_i     (clk),
    .rst_ni    (rst),
    .en_i      (pc_en),
    .pc_next_i (pc_next),
    .pc_o      (pcf)
  );

  assign IMemAddr = pcf;

  // the wrong-path word is squashed on redirect even without FlushD
  always_comb begin
    if_id_d = if_id_q;
    if (FlushD || PCSrcE) begin
      if_id_d.instr    = NOP_INSTR;
      if_id_d.pc       = '0;
      if_id_d.pc_plus4 = '0;
      if_id_d.valid    = 1'b0;
    end else if (!StallD) begin
      if_id_d.instr    = IMemRD;
      if_id_d.pc       = pcf;
      if_id_d.pc_plus4 = pc_plus4f;
      if_id_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc       <= '0;
      if_id_q.pc_plus4 <= '0;
      if_id_q.valid    <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign InstrD   = if_id_q.instr;
  assign PCD      = if_id_q.pc;
  assign PCPlus4D = if_id_q.pc_plus4;
  assign ValidD   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_cycle.sv
// tb/tb_fetch_cycle.sv - directed self-checking bench for fetch_cycle
module tb_fetch_cycle;

  logic        clk;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  logic [31:0] w_IMemAddr;
  logic [31:0] w_IMemRD;
  logic [31:0] w_InstrD;
  logic [31:0] w_PCD;
  logic [31:0] w_PCPlus4D;
  logic        w_ValidD;

  logic [31:0] mem [16];

  int checks;
  int errors;

  fetch_cycle u_dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .IMemAddr  (IMemAddr),
    .IMemRD    (IMemRD),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  fetch_cycle #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (1'b0),
    .PCTargetE (32'h0),
    .StallF    (1'b0),
    .StallD    (1'b0),
    .FlushD    (1'b0),
    .IMemAddr  (w_IMemAddr),
    .IMemRD    (w_IMemRD),
    .InstrD    (w_InstrD),
    .PCD       (w_PCD),
    .PCPlus4D  (w_PCPlus4D),
    .ValidD    (w_ValidD)
  );

  assign IMemRD   = rst ? mem[IMemAddr[5:2]]   : 32'h0;
  assign w_IMemRD = rst ? mem[w_IMemAddr[5:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] pc4, input logic valid);
    check({tag, ".addr"},  IMemAddr, addr);
    check({tag, ".instr"}, InstrD,   instr);
    check({tag, ".pcd"},   PCD,      pc);
    check({tag, ".pc4d"},  PCPlus4D, pc4);
    check({tag, ".valid"}, {31'b0, ValidD}, {31'b0, valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h00A0_0113;
    mem[2]  = 32'h0020_81B3;
    mem[3]  = 32'h0640_0213;
    mem[4]  = 32'h0032_2023;
    mem[5]  = 32'h0002_2283;
    mem[15] = 32'hCAFE_0013;

    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    step(); step();
    check_id("reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
    check("wrap_reset.addr",  w_IMemAddr, 32'hFFFF_FFFC);
    check("wrap_reset.instr", w_InstrD,   32'h13);

    rst = 1'b1;
    step();
    check_id("seq0", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    check("wrap.addr",  w_IMemAddr, 32'h0);
    check("wrap.instr", w_InstrD,   32'hCAFE_0013);
    check("wrap.pcd",   w_PCD,      32'hFFFF_FFFC);
    check("wrap.pc4d",  w_PCPlus4D, 32'h0);
    check("wrap.valid", {31'b0, w_ValidD}, 32'h1);
    step();
    check_id("seq1", 32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1'b1);

    StallF = 1'b1; StallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_id("stall", 32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
    end
    StallF = 1'b0; StallD = 1'b0;
    step();
    check_id("resume0", 32'hC, 32'h0020_81B3, 32'h8, 32'hC, 1'b1);
    step();
    check_id("resume1", 32'h10, 32'h0640_0213, 32'hC, 32'h10, 1'b1);

    PCSrcE = 1'b1; PCTargetE = 32'h0000_0012;
    step();
    check_id("redir_bubble", 32'h10, 32'h13, 32'h0, 32'h0, 1'b0);
    PCSrcE = 1'b0; PCTargetE = 32'h0;
    step();
    check_id("redir_target", 32'h14, 32'h0032_2023, 32'h10, 32'h14, 1'b1);

    FlushD = 1'b1; StallD = 1'b1; StallF = 1'b1;
    step();
    check_id("flush_stall", 32'h14, 32'h13, 32'h0, 32'h0, 1'b0);
    FlushD = 1'b0; StallD = 1'b0; StallF = 1'b0;
    step();
    check_id("after_flush", 32'h18, 32'h0002_2283, 32'h14, 32'h18, 1'b1);

    StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0004;
    step();
    check_id("stall_redir", 32'h4, 32'h13, 32'h0, 32'h0, 1'b0);
    StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    step();
    check_id("stall_redir_tgt", 32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1'b1);

    StallF = 1'b1; StallD = 1'b1;
    step(); step();
    check_id("stall2", 32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1'b1);
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0020;
    #2;
    rst = 1'b0;
    #1;
    check_id("async_reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
    PCSrcE = 1'b0; PCTargetE = 32'h0; StallF = 1'b0; StallD = 1'b0;
    step();
    check_id("held_reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    step();
    check_id("rerelease", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
